jk_seq_ctrl: RTL

JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

---
 rtl/jk_seq_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: sequences a bank of WIDTH JK flip-flops through clear, set,
// load, toggle and multi-step binary count commands over a valid/ready
// command port. J/K are registered on the rising edge; the bank itself
// samples them on the falling edge and reports its state back on Q_FB.
//
// Optional feature (macro JK_SEQ_LOAD_CHECK_EN): after a LOAD, Q_FB is
// compared with the loaded value as the FSM enters FIN. ERR flags a
// mismatch together with DONE and holds until the next command is accepted.
// Without the macro, ERR is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, CMD_READY=1, J=K=0
// S_APPLY | one cycle of CLEAR/SET/LOAD/TOGGLE drive on J/K
// S_COUNT | one count step per cycle, step_cnt cycles in total
// S_FIN   | DONE pulse, J=K=0, back to S_IDLE next cycle
module jk_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [7:0]       CMD_CNT,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_UP     = 3'b101;
  localparam logic [2:0] OP_DOWN   = 3'b110;

  logic [1:0]       state;
  logic [2:0]       op_lat;
  logic [7:0]       step_cnt;
  logic [WIDTH-1:0] up_jk;
  logic [WIDTH-1:0] dn_jk;

  // Bit i toggles when every lower bit is 1; bit 0 always toggles.
  function automatic logic [WIDTH-1:0] carry_chain(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    logic             acc;
    acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = acc;
      acc  = acc & v[i];
    end
    return r;
  endfunction

  // Toggle enables for one increment (from Q) or one decrement (from ~Q).
  assign up_jk = carry_chain(Q_FB);
  assign dn_jk = carry_chain(~Q_FB);

  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state == S_APPLY) || (state == S_COUNT);
  assign DONE      = (state == S_FIN);

  // Command FSM with registered J/K; J/K default to hold (0) every cycle.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= S_IDLE;
      op_lat   <= 3'b000;
      step_cnt <= 8'd0;
      J        <= '0;
      K        <= '0;
    end else begin
      J <= '0;
      K <= '0;
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            op_lat   <= CMD_OP;
            step_cnt <= CMD_CNT;
            case (CMD_OP)
              OP_CLEAR: begin
                state <= S_APPLY;
                K     <= '1;
              end
              OP_SET: begin
                state <= S_APPLY;
                J     <= '1;
              end
              OP_LOAD: begin
                state <= S_APPLY;
                J     <= CMD_DATA;
                K     <= ~CMD_DATA;
              end
              OP_TOGGLE: begin
                state <= S_APPLY;
                J     <= CMD_DATA;
                K     <= CMD_DATA;
              end
              OP_UP, OP_DOWN: begin
                if (CMD_CNT != 8'd0) begin
                  state <= S_COUNT;
                  J     <= (CMD_OP == OP_UP) ? up_jk : dn_jk;
                  K     <= (CMD_OP == OP_UP) ? up_jk : dn_jk;
                end else begin
                  state <= S_FIN;
                end
              end
              default: state <= S_FIN;
            endcase
          end
        end
        S_APPLY: state <= S_FIN;
        S_COUNT: begin
          if (step_cnt == 8'd1) begin
            state <= S_FIN;
          end else begin
            step_cnt <= step_cnt - 8'd1;
            J        <= (op_lat == OP_UP) ? up_jk : dn_jk;
            K        <= (op_lat == OP_UP) ? up_jk : dn_jk;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef JK_SEQ_LOAD_CHECK_EN
  logic [WIDTH-1:0] data_lat;
  logic             err_q;

  // Load verification: Q_FB has settled by the APPLY->FIN edge.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      data_lat <= '0;
      err_q    <= 1'b0;
    end else if (state == S_IDLE && CMD_VALID) begin
      data_lat <= CMD_DATA;
      err_q    <= 1'b0;
    end else if (state == S_APPLY && op_lat == OP_LOAD) begin
      err_q <= (Q_FB != data_lat);
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
